// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the channel scan sequencer.
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/next_ch_finder.sv
// Combinational search over the channel mask: the lowest enabled channel
// strictly above the current one, and the lowest enabled channel overall.
module next_ch_finder
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [SEL_W-1:0]  sel,
  output logic [SEL_W-1:0]  next_ch,
  output logic              wrap,
  output logic [SEL_W-1:0]  first_ch,
  output logic              any_en
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    next_ch = '0;
    wrap    = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && (i > int'(sel))) begin
        next_ch = SEL_W'(i);
        wrap    = 1'b0;
      end
    end
  end

  // Lowest enabled channel, used on frame start and on continuous wrap.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_ch = SEL_W'(i);
      end
    end
  end

  assign any_en = |ch_mask;

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-to-8 decoder select through the enabled channels of ch_mask,
// holding each channel for a programmable dwell count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no scan active; sel = 0, sel_valid = 0
//   ST_DWELL | holding sel on one channel while the dwell counter runs
//
// frame_done is decoded from registered state plus the live mask/stop so it
// lines up with the last dwell cycle of the frame rather than one cycle late.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               frame_done,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;

  logic [DWELL_W-1:0] dwell_load;
  logic [SEL_W-1:0]   next_ch;
  logic [SEL_W-1:0]   first_ch;
  logic               wrap;
  logic               any_en;

  next_ch_finder u_next_ch_finder (
    .ch_mask  (ch_mask),
    .sel      (sel_q),
    .next_ch  (next_ch),
    .wrap     (wrap),
    .first_ch (first_ch),
    .any_en   (any_en)
  );

  // A dwell of 0 behaves as 1: the channel still gets one cycle.
  assign dwell_load = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

  // Next-state, counter and select decode; frame_done marks the last frame cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    frame_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop && any_en) begin
          state_d     = ST_DWELL;
          sel_d       = first_ch;
          sel_valid_d = 1'b1;
          cnt_d       = dwell_load;
        end
      end

      ST_DWELL: begin
        if (stop) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          sel_d       = '0;
          sel_valid_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (!any_en) begin
          // Mask emptied under us: close the frame and drop back to idle.
          frame_done  = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
          sel_d       = '0;
          sel_valid_d = 1'b0;
        end else if (!wrap) begin
          sel_d = next_ch;
          cnt_d = dwell_load;
        end else begin
          frame_done = 1'b1;
          if (continuous) begin
            sel_d = first_ch;
            cnt_d = dwell_load;
          end else begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            sel_d       = '0;
            sel_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        sel_d       = '0;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = (state_q == ST_DWELL);

endmodule

// File: tb/tb_scan_sequencer.sv
// Scenario bench for scan_sequencer: each task queues the per-cycle output
// it expects, then drives stimulus and compares one queue entry per cycle.
module tb_scan_sequencer;

  localparam int DWELL_W = 8;
  localparam logic [5:0] E_IDLE = 6'b000000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               continuous = 1'b0;
  logic [7:0]         ch_mask = 8'h00;
  logic [DWELL_W-1:0] dwell = '0;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               frame_done;
  logic               busy;

  logic [5:0] obs;
  logic [5:0] exp_v;
  logic [5:0] sb_q[$];
  int n_pass = 0;
  int n_total = 0;

  assign obs = {busy, frame_done, sel_valid, sel};

  always #5 clk = ~clk;

  scan_sequencer #(.NUM_CH(8), .DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // Expected word for a cycle spent dwelling on channel ch.
  function automatic logic [5:0] e_dw(input int ch, input bit fd);
    return {1'b1, fd, 1'b1, 3'(ch)};
  endfunction

  task automatic test_reset();
    start = 1'b1; ch_mask = 8'hFF; dwell = 8'd2; rst_n = 1'b0;
    for (int k = 0; k < 3; k++) sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL reset[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    ch_mask = 8'hFF; dwell = 8'd2; continuous = 1'b0;
    sb_q.push_back(E_IDLE);
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 2; k++) sb_q.push_back(e_dw(c, (c == 7) && (k == 1)));
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0) || (i == 6);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL single_frame[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_continuous();
    int seq [3];
    seq = '{2, 5, 7};
    ch_mask = 8'b1010_0100; dwell = 8'd1; continuous = 1'b1;
    sb_q.push_back(E_IDLE);
    for (int k = 0; k < 9; k++) sb_q.push_back(e_dw(seq[k % 3], seq[k % 3] == 7));
    sb_q.push_back(e_dw(2, 1'b0));
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0);
      stop  = (i == 10);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL continuous[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_stop();
    ch_mask = 8'h08; dwell = 8'd4; continuous = 1'b0;
    sb_q.push_back(E_IDLE);
    sb_q.push_back(e_dw(3, 1'b0));
    sb_q.push_back(e_dw(3, 1'b0));
    sb_q.push_back(E_IDLE);
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0);
      stop  = (i == 2);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL stop[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_no_start();
    dwell = 8'd1; continuous = 1'b0;
    for (int k = 0; k < 5; k++) sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      ch_mask = (i < 2) ? 8'h00 : 8'hFF;
      start   = (i == 0) || (i == 2);
      stop    = (i == 2);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL no_start[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_mask_change();
    ch_mask = 8'h10; dwell = 8'd3; continuous = 1'b1;
    sb_q.push_back(E_IDLE);
    sb_q.push_back(e_dw(4, 1'b0));
    sb_q.push_back(e_dw(4, 1'b0));
    sb_q.push_back(e_dw(4, 1'b1));
    sb_q.push_back(e_dw(1, 1'b0));
    sb_q.push_back(e_dw(1, 1'b0));
    sb_q.push_back(e_dw(1, 1'b1));
    sb_q.push_back(e_dw(1, 1'b0));
    sb_q.push_back(e_dw(1, 1'b0));
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0);
      stop  = (i == 8);
      if (i == 1) ch_mask = 8'h02;
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL mask_change[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_mask_zero();
    ch_mask = 8'h08; dwell = 8'd2; continuous = 1'b1;
    sb_q.push_back(E_IDLE);
    sb_q.push_back(e_dw(3, 1'b0));
    sb_q.push_back(e_dw(3, 1'b1));
    sb_q.push_back(E_IDLE);
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0);
      if (i == 2) ch_mask = 8'h00;
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL mask_zero[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_dwell_change();
    ch_mask = 8'h03; dwell = 8'd3; continuous = 1'b0;
    sb_q.push_back(E_IDLE);
    for (int k = 0; k < 3; k++) sb_q.push_back(e_dw(0, 1'b0));
    sb_q.push_back(e_dw(1, 1'b1));
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0);
      if (i == 1) dwell = 8'd1;
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL dwell_change[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    ch_mask = 8'h81; dwell = 8'd3; continuous = 1'b1;
    sb_q.push_back(E_IDLE);
    sb_q.push_back(e_dw(0, 1'b0));
    sb_q.push_back(e_dw(0, 1'b0));
    sb_q.push_back(E_IDLE);
    sb_q.push_back(E_IDLE);
    sb_q.push_back(E_IDLE);
    sb_q.push_back(E_IDLE);
    for (int k = 0; k < 3; k++) sb_q.push_back(e_dw(0, 1'b0));
    sb_q.push_back(e_dw(7, 1'b0));
    sb_q.push_back(E_IDLE);
    for (int i = 0; sb_q.size() != 0; i++) begin
      rst_n = !((i == 2) || (i == 4));
      start = (i == 0) || (i == 4) || (i == 6);
      stop  = (i == 10);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL reset_mid[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_dwell_zero();
    ch_mask = 8'h06; continuous = 1'b0;
    for (int r = 0; r < 2; r++) begin
      sb_q.push_back(E_IDLE);
      sb_q.push_back(e_dw(1, 1'b0));
      sb_q.push_back(e_dw(2, 1'b1));
      sb_q.push_back(E_IDLE);
    end
    for (int i = 0; sb_q.size() != 0; i++) begin
      start = (i == 0) || (i == 4);
      dwell = (i < 4) ? 8'd0 : 8'd1;
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_total++;
      if (obs !== exp_v) $display("FAIL dwell_zero[%0d]: got busy/fd/valid/sel=%b want %b", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_stop();
    test_no_start();
    test_mask_change();
    test_mask_zero();
    test_dwell_change();
    test_reset_mid();
    test_dwell_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter: NUM_CH, 8, number of scanned channels (fixed at 8; sel feeds a 3-to-8 decoder).
REQ-002 SHALL have parameter: DWELL_W, 8, width of the per-channel dwell count.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port: start  input  1  one-cycle request to begin a scan frame.
REQ-006 SHALL have port: stop  input  1  abort request; overrides start.
REQ-007 SHALL have port: continuous  input  1  1 = repeat frames, 0 = single frame.
REQ-008 SHALL have port: ch_mask  input  8  channel enable mask, bit i enables channel i.
REQ-009 SHALL have port: dwell  input  DWELL_W  cycles spent on each channel; 0 treated as 1.
REQ-010 SHALL have port: sel  output  3  current channel code, drives decoder select input.
REQ-011 SHALL have port: sel_valid  output  1  sel is meaningful; decoder output enabled.
REQ-012 SHALL have port: frame_done  output  1  one-cycle pulse on the last cycle of a frame.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and DWELL; busy = (state == DWELL).
REQ-015 In IDLE, sel SHALL be 0 and sel_valid, frame_done SHALL be 0.
REQ-016 IDLE->DWELL SHALL occur when start=1, stop=0, ch_mask!=0; sel = lowest set bit of ch_mask, sel_valid=1 in the next cycle (latency 1).
REQ-017 start with ch_mask=0, or start and stop in the same cycle, SHALL leave the block in IDLE.
REQ-018 start while busy SHALL be ignored.
REQ-019 On entry to each channel, the dwell counter SHALL load max(dwell,1)-1; dwell changes take effect at the next channel entry only.
REQ-020 The counter SHALL decrement each DWELL cycle; the cycle where it equals 0 is the channel's last cycle.
REQ-021 On the last cycle, the next channel SHALL be the lowest enabled index above sel in the current ch_mask; sel updates in the following cycle.
REQ-022 If no higher enabled channel exists, frame_done SHALL be 1 during that last cycle (wrap condition).
REQ-023 On wrap: continuous=1 -> next sel = lowest enabled channel; continuous=0 -> IDLE.
REQ-024 If ch_mask=0 at an advance decision, the block SHALL assert frame_done and return to IDLE.
REQ-025 stop=1 in DWELL SHALL force IDLE in the next cycle with no frame_done, even on a last cycle.
REQ-026 sel and sel_valid SHALL be registered and change only on clock edges, never glitching between channels.
REQ-027 A single-enabled-channel mask with continuous=1 SHALL assert frame_done at the end of every dwell period.

Reset
REQ-028 While rst_n=0 at a clock edge: state=IDLE, counter=0, sel=0, sel_valid=0, frame_done=0, busy=0.
REQ-029 Reset SHALL take precedence over start, stop and any in-progress dwell.

Structure
REQ-030 Package scan_pkg SHALL hold NUM_CH, SEL_W=3, and the state enum type.
REQ-031 Sub-module next_ch_finder SHALL compute the next enabled index and wrap flag from (ch_mask, sel) combinationally.

Verification
REQ-032 mask=8'hFF, dwell=2, continuous=0, start -> sel 0,0,1,1,...,7,7; frame_done on the second ch7 cycle; IDLE next.
REQ-033 mask=8'b1010_0100, dwell=1, continuous=1 -> sel 2,5,7,2,5,7...; frame_done high on every sel=7 cycle.
REQ-034 Scanning ch3 with dwell=4, stop in the second cycle -> sel_valid=0 next cycle; no frame_done.
REQ-035 start with mask=0 -> stays IDLE; start and stop together -> stays IDLE.
REQ-036 mask changed to 8'h02 while on ch4, continuous=1 -> frame_done on ch4's last cycle, then sel=1.
REQ-037 rst_n=0 mid-DWELL -> all outputs 0 next cycle; dwell=0 behaves identically to dwell=1.
